// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: buffers completed instructions and retires one per cycle as
// register-file write pulses, checks SAVE/RESTORE against WIM, and forwards pending results.
module wb_retire_stage #(
    parameter int FIFO_DEPTH = 2,
    parameter int NWINDOWS   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_data,
    input  logic        in_wr,
    input  logic        in_dbl,
    input  logic        in_icc_en,
    input  logic [3:0]  in_icc,
    input  logic        in_y_en,
    input  logic        in_save,
    input  logic        in_restore,
    input  logic        in_et_inc,
    input  logic        in_et_dec,
    input  logic [31:0] wim,
    output logic        reg_write_en,
    output logic        reg_writeDouble_en,
    output logic [4:0]  wr_reg,
    output logic [63:0] data,
    output logic        icc_en,
    output logic [3:0]  icc_in,
    output logic        Y_en,
    output logic        cwp_inc,
    output logic        cwp_dec,
    output logic        et_inc,
    output logic        et_dec,
    output logic        trap_req,
    output logic [1:0]  trap_type,
    input  logic        trap_ack,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd1_val,
    output logic [31:0] fwd2_val,
    output logic [4:0]  shadow_cwp,
    output logic [31:0] retired_cnt
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);
    localparam logic [4:0] CWP_MAX = 5'(NWINDOWS - 1);
    localparam int C_WR = 7, C_DBL = 6, C_ICC = 5, C_Y = 4, C_SAVE = 3, C_REST = 2, C_ETI = 1, C_ETD = 0;

    typedef enum logic {S_RUN = 1'b0, S_TRAP = 1'b1} state_t;
    state_t r_state, w_state_next;

    logic [4:0]    r_q_rd   [FIFO_DEPTH];
    logic [63:0]   r_q_data [FIFO_DEPTH];
    logic [3:0]    r_q_icc  [FIFO_DEPTH];
    logic [7:0]    r_q_ctl  [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full, w_push, w_pop, w_trap, w_retire, w_upd_data;
    logic          w_do_save, w_do_restore;
    logic [4:0]    w_h_rd, w_cwp_m1, w_cwp_p1;
    logic [63:0]   w_h_data;
    logic [3:0]    w_h_icc;
    logic [7:0]    w_h_ctl;
    logic [32:0]   w_fwd1, w_fwd2;

    assign w_full   = (r_count == DEPTH_V);
    assign in_ready = reset && (r_state == S_RUN) && !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == S_RUN) && (r_count != '0);

    assign w_h_rd   = r_q_rd[r_rd_ptr];
    assign w_h_data = r_q_data[r_rd_ptr];
    assign w_h_icc  = r_q_icc[r_rd_ptr];
    assign w_h_ctl  = r_q_ctl[r_rd_ptr];

    // SAVE together with RESTORE cancels both the window move and the check.
    assign w_do_save    = w_h_ctl[C_SAVE] && !w_h_ctl[C_REST];
    assign w_do_restore = w_h_ctl[C_REST] && !w_h_ctl[C_SAVE];
    assign w_cwp_m1     = (shadow_cwp == 5'd0) ? CWP_MAX : shadow_cwp - 5'd1;
    assign w_cwp_p1     = (shadow_cwp == CWP_MAX) ? 5'd0 : shadow_cwp + 5'd1;
    assign w_trap       = w_pop && ((w_do_save && wim[w_cwp_m1]) || (w_do_restore && wim[w_cwp_p1]));
    assign w_retire     = w_pop && !w_trap;
    assign w_upd_data   = w_retire && ((w_h_ctl[C_WR] && ((w_h_rd != 5'd0) || w_h_ctl[C_DBL])) || w_h_ctl[C_Y]);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_wr_ptr]   <= in_rd;
            r_q_data[r_wr_ptr] <= in_data;
            r_q_icc[r_wr_ptr]  <= in_icc;
            r_q_ctl[r_wr_ptr]  <= {in_wr, in_dbl, in_icc_en, in_y_en, in_save, in_restore, in_et_inc, in_et_dec};
        end
    end

    // A trap flushes everything, including an entry pushed on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_trap) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_en       <= 1'b0;
            reg_writeDouble_en <= 1'b0;
            icc_en             <= 1'b0;
            icc_in             <= '0;
            Y_en               <= 1'b0;
            cwp_inc            <= 1'b0;
            cwp_dec            <= 1'b0;
            et_inc             <= 1'b0;
            et_dec             <= 1'b0;
            wr_reg             <= '0;
            data               <= '0;
            shadow_cwp         <= '0;
            retired_cnt        <= '0;
        end else begin
            reg_write_en       <= w_retire && w_h_ctl[C_WR] && (w_h_rd != 5'd0);
            reg_writeDouble_en <= w_retire && w_h_ctl[C_WR] && w_h_ctl[C_DBL];
            icc_en             <= w_retire && w_h_ctl[C_ICC];
            icc_in             <= (w_retire && w_h_ctl[C_ICC]) ? w_h_icc : 4'd0;
            Y_en               <= w_retire && w_h_ctl[C_Y];
            cwp_inc            <= w_retire && w_do_restore;
            cwp_dec            <= w_retire && w_do_save;
            et_inc             <= w_retire && w_h_ctl[C_ETI] && !w_h_ctl[C_ETD];
            et_dec             <= w_retire && w_h_ctl[C_ETD];
            if (w_upd_data) begin
                wr_reg <= w_h_rd;
                data   <= w_h_data;
            end
            if (w_retire) begin
                retired_cnt <= retired_cnt + 32'd1;
                if (w_do_save)         shadow_cwp <= w_cwp_m1;
                else if (w_do_restore) shadow_cwp <= w_cwp_p1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RUN;
            trap_req  <= 1'b0;
            trap_type <= 2'b00;
        end else begin
            r_state <= w_state_next;
            if (w_trap) begin
                trap_req  <= 1'b1;
                trap_type <= w_do_save ? 2'b01 : 2'b10;
            end else if (r_state == S_TRAP && trap_ack) begin
                trap_req  <= 1'b0;
                trap_type <= 2'b00;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:   if (w_trap) w_state_next = S_TRAP;
            S_TRAP:  if (trap_ack) w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    // Retiring strobe is the oldest candidate; queued entries override it oldest to youngest.
    function automatic logic [32:0] fwd_lookup(input logic [4:0] rs);
        logic [32:0]   res;
        logic [AW-1:0] idx;
        res = '0;
        idx = '0;
        if (rs != 5'd0) begin
            if (reg_write_en && wr_reg == rs)
                res = {1'b1, data[31:0]};
            else if (reg_writeDouble_en && (wr_reg + 5'd1) == rs)
                res = {1'b1, data[63:32]};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (i < int'(r_count)) begin
                    idx = r_rd_ptr + AW'(i);
                    if (r_q_ctl[idx][C_WR] && r_q_rd[idx] == rs)
                        res = {1'b1, r_q_data[idx][31:0]};
                    else if (r_q_ctl[idx][C_WR] && r_q_ctl[idx][C_DBL] && (r_q_rd[idx] + 5'd1) == rs)
                        res = {1'b1, r_q_data[idx][63:32]};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        w_fwd1 = fwd_lookup(rs1);
        w_fwd2 = fwd_lookup(rs2);
    end

    assign fwd1_hit = w_fwd1[32];
    assign fwd1_val = w_fwd1[31:0];
    assign fwd2_hit = w_fwd2[32];
    assign fwd2_val = w_fwd2[31:0];
endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed bench for wb_retire_stage: drives on the falling edge, samples on the falling edge.
module tb_wb_retire_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [4:0]  in_rd;
    logic [63:0] in_data;
    logic        in_wr, in_dbl, in_icc_en, in_y_en, in_save, in_restore, in_et_inc, in_et_dec;
    logic [3:0]  in_icc;
    logic [31:0] wim;
    logic        reg_write_en, reg_writeDouble_en;
    logic [4:0]  wr_reg;
    logic [63:0] data;
    logic        icc_en;
    logic [3:0]  icc_in;
    logic        Y_en, cwp_inc, cwp_dec, et_inc, et_dec;
    logic        trap_req;
    logic [1:0]  trap_type;
    logic        trap_ack;
    logic [4:0]  rs1, rs2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_val, fwd2_val;
    logic [4:0]  shadow_cwp;
    logic [31:0] retired_cnt;

    int errors = 0;
    int checks = 0;

    wb_retire_stage #(.FIFO_DEPTH(2), .NWINDOWS(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .in_wr(in_wr), .in_dbl(in_dbl),
        .in_icc_en(in_icc_en), .in_icc(in_icc), .in_y_en(in_y_en),
        .in_save(in_save), .in_restore(in_restore), .in_et_inc(in_et_inc), .in_et_dec(in_et_dec),
        .wim(wim), .reg_write_en(reg_write_en), .reg_writeDouble_en(reg_writeDouble_en),
        .wr_reg(wr_reg), .data(data), .icc_en(icc_en), .icc_in(icc_in), .Y_en(Y_en),
        .cwp_inc(cwp_inc), .cwp_dec(cwp_dec), .et_inc(et_inc), .et_dec(et_dec),
        .trap_req(trap_req), .trap_type(trap_type), .trap_ack(trap_ack),
        .rs1(rs1), .rs2(rs2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_val(fwd1_val), .fwd2_val(fwd2_val), .shadow_cwp(shadow_cwp), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        in_valid = 1'b0; in_rd = '0; in_data = '0; in_icc = '0;
        {in_wr, in_dbl, in_icc_en, in_y_en, in_save, in_restore, in_et_inc, in_et_dec} = '0;
    endtask

    // ctl = {wr, dbl, icc_en, y_en, save, restore, et_inc, et_dec}
    task automatic drive(input logic [4:0] rd, input logic [63:0] d, input logic [7:0] ctl, input logic [3:0] icc);
        in_valid = 1'b1; in_rd = rd; in_data = d; in_icc = icc;
        {in_wr, in_dbl, in_icc_en, in_y_en, in_save, in_restore, in_et_inc, in_et_dec} = ctl;
    endtask

    task automatic test_reset();
        reset = 1'b0; trap_ack = 1'b0; wim = '0; rs1 = '0; rs2 = '0;
        idle();
        #3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        checks++; if ({reg_write_en, reg_writeDouble_en, icc_en, Y_en, cwp_inc, cwp_dec, et_inc, et_dec, trap_req} !== 9'd0) begin
            errors++; $display("FAIL rst_strobes: got %b want 0", {reg_write_en, reg_writeDouble_en, icc_en, Y_en, cwp_inc, cwp_dec, et_inc, et_dec, trap_req}); end
        checks++; if ({wr_reg, data, icc_in, trap_type} !== 75'd0) begin errors++; $display("FAIL rst_regs: wr_reg=%h data=%h icc_in=%h trap_type=%b want 0", wr_reg, data, icc_in, trap_type); end
        checks++; if ({shadow_cwp, retired_cnt} !== 37'd0) begin errors++; $display("FAIL rst_cnt: cwp=%0d cnt=%0d want 0", shadow_cwp, retired_cnt); end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        @(negedge clk);
        drive(5'd9, 64'h0000_0000_DEAD_BEEF, 8'b1000_0000, 4'h0);
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", reg_write_en); end
        idle();
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b1 || reg_writeDouble_en !== 1'b0) begin errors++; $display("FAIL single_we: we=%b dbl=%b want 1 0", reg_write_en, reg_writeDouble_en); end
        checks++; if (wr_reg !== 5'd9 || data[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: reg=%0d data=%h want 9 deadbeef", wr_reg, data[31:0]); end
        checks++; if (retired_cnt !== 32'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", retired_cnt); end
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0 || wr_reg !== 5'd9) begin errors++; $display("FAIL single_pulse: we=%b reg=%0d want 0 9", reg_write_en, wr_reg); end
    endtask

    task automatic test_forward_double();
        @(negedge clk);
        drive(5'd4, 64'h1111_2222_3333_4444, 8'b1100_0000, 4'h0);
        rs1 = 5'd5; rs2 = 5'd4;
        #1;
        checks++; if (fwd1_hit !== 1'b0) begin errors++; $display("FAIL fwd_input_only: got %b want 0", fwd1_hit); end
        @(negedge clk);
        checks++; if (fwd1_hit !== 1'b1 || fwd1_val !== 32'h1111_2222) begin errors++; $display("FAIL fwd1_queued: hit=%b val=%h want 1 11112222", fwd1_hit, fwd1_val); end
        checks++; if (fwd2_hit !== 1'b1 || fwd2_val !== 32'h3333_4444) begin errors++; $display("FAIL fwd2_queued: hit=%b val=%h want 1 33334444", fwd2_hit, fwd2_val); end
        checks++; if (reg_writeDouble_en !== 1'b0) begin errors++; $display("FAIL dbl_early: got %b want 0", reg_writeDouble_en); end
        idle();
        @(negedge clk);
        checks++; if (reg_writeDouble_en !== 1'b1 || reg_write_en !== 1'b1 || wr_reg !== 5'd4) begin
            errors++; $display("FAIL dbl_strobe: dbl=%b we=%b reg=%0d want 1 1 4", reg_writeDouble_en, reg_write_en, wr_reg); end
        checks++; if (fwd1_hit !== 1'b1 || fwd1_val !== 32'h1111_2222) begin errors++; $display("FAIL fwd1_strobe: hit=%b val=%h want 1 11112222", fwd1_hit, fwd1_val); end
        @(negedge clk);
        checks++; if (reg_writeDouble_en !== 1'b0 || fwd1_hit !== 1'b0) begin errors++; $display("FAIL dbl_after: dbl=%b hit=%b want 0 0", reg_writeDouble_en, fwd1_hit); end
        checks++; if (retired_cnt !== 32'd2) begin errors++; $display("FAIL dbl_cnt: got %0d want 2", retired_cnt); end
    endtask

    task automatic test_window_overflow();
        wim = 32'h1;
        @(negedge clk);
        drive(5'd0, 64'h0, 8'b0000_1000, 4'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (cwp_dec !== 1'b1 || cwp_inc !== 1'b0 || trap_req !== 1'b0) begin errors++; $display("FAIL save_ok: dec=%b inc=%b trap=%b want 1 0 0", cwp_dec, cwp_inc, trap_req); end
        checks++; if (shadow_cwp !== 5'd1) begin errors++; $display("FAIL save_cwp: got %0d want 1", shadow_cwp); end
        @(negedge clk);
        drive(5'd0, 64'h0, 8'b0000_1000, 4'h0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_before: got %b want 1", in_ready); end
        drive(5'd7, 64'h77, 8'b1000_0000, 4'h0);
        @(negedge clk);
        checks++; if (trap_req !== 1'b1 || trap_type !== 2'b01) begin errors++; $display("FAIL ovf_trap: req=%b type=%b want 1 01", trap_req, trap_type); end
        checks++; if (cwp_dec !== 1'b0 || shadow_cwp !== 5'd1 || retired_cnt !== 32'd3) begin
            errors++; $display("FAIL ovf_side: dec=%b cwp=%0d cnt=%0d want 0 1 3", cwp_dec, shadow_cwp, retired_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b want 0", in_ready); end
        idle();
        @(negedge clk);
        checks++; if (trap_req !== 1'b1 || reg_write_en !== 1'b0) begin errors++; $display("FAIL ovf_hold: req=%b we=%b want 1 0", trap_req, reg_write_en); end
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        checks++; if (trap_req !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ovf_ack: req=%b ready=%b want 0 1", trap_req, in_ready); end
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0 || retired_cnt !== 32'd3) begin errors++; $display("FAIL ovf_flush: we=%b cnt=%0d want 0 3", reg_write_en, retired_cnt); end
    endtask

    task automatic test_window_underflow();
        wim = 32'h1;
        @(negedge clk);
        drive(5'd0, 64'h0, 8'b0000_0100, 4'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (trap_req !== 1'b1 || trap_type !== 2'b10 || cwp_inc !== 1'b0) begin
            errors++; $display("FAIL unf_trap: req=%b type=%b inc=%b want 1 10 0", trap_req, trap_type, cwp_inc); end
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        wim = 32'h0;
        drive(5'd0, 64'h0, 8'b0000_0100, 4'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (cwp_inc !== 1'b1 || shadow_cwp !== 5'd0 || retired_cnt !== 32'd4) begin
            errors++; $display("FAIL restore_ok: inc=%b cwp=%0d cnt=%0d want 1 0 4", cwp_inc, shadow_cwp, retired_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] rd_exp;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                rd_exp = 5'(10 + k - 2);
                checks++; if (reg_write_en !== 1'b1 || wr_reg !== rd_exp || data[31:0] !== (32'hB0B0_0000 | 32'(k - 2))) begin
                    errors++; $display("FAIL b2b_strobe%0d: we=%b reg=%0d data=%h want 1 %0d %h", k - 2, reg_write_en, wr_reg, data[31:0], rd_exp, 32'hB0B0_0000 | 32'(k - 2)); end
            end
            if (k < 6) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready); end
                drive(5'(10 + k), {32'h0, 32'hB0B0_0000 | 32'(k)}, 8'b1000_0000, 4'h0);
            end else begin
                idle();
            end
        end
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0 || retired_cnt !== 32'd10) begin errors++; $display("FAIL b2b_end: we=%b cnt=%0d want 0 10", reg_write_en, retired_cnt); end
    endtask

    task automatic test_rd0_icc();
        rs1 = 5'd0;
        @(negedge clk);
        drive(5'd0, 64'h5555, 8'b1010_0000, 4'hA);
        @(negedge clk);
        checks++; if (fwd1_hit !== 1'b0) begin errors++; $display("FAIL rd0_fwd_q: got %b want 0", fwd1_hit); end
        idle();
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0 || reg_writeDouble_en !== 1'b0) begin errors++; $display("FAIL rd0_we: we=%b dbl=%b want 0 0", reg_write_en, reg_writeDouble_en); end
        checks++; if (icc_en !== 1'b1 || icc_in !== 4'hA) begin errors++; $display("FAIL rd0_icc: en=%b icc=%h want 1 a", icc_en, icc_in); end
        checks++; if (wr_reg !== 5'd15 || fwd1_hit !== 1'b0) begin errors++; $display("FAIL rd0_hold: reg=%0d hit=%b want 15 0", wr_reg, fwd1_hit); end
        checks++; if (retired_cnt !== 32'd11) begin errors++; $display("FAIL rd0_cnt: got %0d want 11", retired_cnt); end
        @(negedge clk);
        checks++; if (icc_en !== 1'b0) begin errors++; $display("FAIL rd0_icc_pulse: got %b want 0", icc_en); end
    endtask

    task automatic test_et_y();
        @(negedge clk);
        drive(5'd3, 64'hCAFE_F00D_0000_0003, 8'b1001_0011, 4'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (Y_en !== 1'b1 || data[63:32] !== 32'hCAFE_F00D) begin errors++; $display("FAIL y_write: en=%b hi=%h want 1 cafef00d", Y_en, data[63:32]); end
        checks++; if (et_dec !== 1'b1 || et_inc !== 1'b0) begin errors++; $display("FAIL et_both: dec=%b inc=%b want 1 0", et_dec, et_inc); end
        checks++; if (reg_write_en !== 1'b1 || wr_reg !== 5'd3 || retired_cnt !== 32'd12) begin
            errors++; $display("FAIL et_gpr: we=%b reg=%0d cnt=%0d want 1 3 12", reg_write_en, wr_reg, retired_cnt); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(5'd20, 64'h20, 8'b1000_0000, 4'h0);
        @(negedge clk);
        drive(5'd21, 64'h21, 8'b1000_0000, 4'h0);
        @(negedge clk);
        idle();
        checks++; if (reg_write_en !== 1'b1 || wr_reg !== 5'd20) begin errors++; $display("FAIL mid_pre: we=%b reg=%0d want 1 20", reg_write_en, wr_reg); end
        #2 reset = 1'b0;
        #1;
        checks++; if (reg_write_en !== 1'b0 || wr_reg !== 5'd0 || data !== 64'd0) begin
            errors++; $display("FAIL mid_async: we=%b reg=%0d data=%h want 0 0 0", reg_write_en, wr_reg, data); end
        checks++; if (retired_cnt !== 32'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_cnt: cnt=%0d ready=%b want 0 0", retired_cnt, in_ready); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release: got %b want 1", in_ready); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL mid_discard: we=%b cnt=%0d want 0 0", reg_write_en, retired_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_forward_double();
        test_window_overflow();
        test_window_underflow();
        test_back_to_back();
        test_rd0_icc();
        test_et_y();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
